// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the datapath sequencer.
package ctrl_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  // Decoded instruction classes that steer the sequence.
  typedef enum logic [2:0] {
    CLS_MOVI    = 3'd0,
    CLS_MOVR    = 3'd1,
    CLS_ALU3    = 3'd2,
    CLS_CMP     = 3'd3,
    CLS_MVN     = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_t;

  // Opcode field values.
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Op field values.
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Shifter encodings.
  localparam logic [1:0] SHIFT_NONE = 2'b00;
  localparam logic [1:0] SHIFT_LSL  = 2'b01;
  localparam logic [1:0] SHIFT_LSR  = 2'b10;
  localparam logic [1:0] SHIFT_ASR  = 2'b11;

  // ALU encodings.
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Sign-extend an 8-bit immediate to the 16-bit datapath width.
  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/datapath_controller_instr_decoder.sv
// Combinational instruction decoder: splits the latched instruction into
// fields and classifies it for the sequencer.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [15:0]  ir,
  output logic [1:0]   op,
  output logic [2:0]   rn,
  output logic [2:0]   rd,
  output logic [1:0]   sh,
  output logic [2:0]   rm,
  output logic [15:0]  imm_ext,
  output instr_class_t cls
);

  logic [2:0] opcode;

  assign opcode  = ir[15:13];
  assign op      = ir[12:11];
  assign rn      = ir[10:8];
  assign rd      = ir[7:5];
  assign sh      = ir[4:3];
  assign rm      = ir[2:0];
  assign imm_ext = sext8(ir[7:0]);

  // Classify opcode/op; anything not explicitly recognised is illegal.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      cls = CLS_MOVI;
        else if (op == OP_MOV_REG) cls = CLS_MOVR;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD, OP_AND: cls = CLS_ALU3;
          OP_CMP:         cls = CLS_CMP;
          OP_MVN:         cls = CLS_MVN;
          default:        cls = CLS_ILLEGAL;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// Moore sequencer that runs one instruction per start pulse by driving the
// register-file / shifter / ALU datapath strobes cycle by cycle.
module datapath_controller
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in
);

  state_t       state_q, state_d;
  logic [15:0]  ir_q, ir_d;

  logic [1:0]   f_op;
  logic [2:0]   f_rn, f_rd, f_rm;
  logic [1:0]   f_sh;
  logic [15:0]  f_imm;
  instr_class_t f_cls;

  instr_decoder u_dec (
    .ir      (ir_q),
    .op      (f_op),
    .rn      (f_rn),
    .rd      (f_rd),
    .sh      (f_sh),
    .rm      (f_rm),
    .imm_ext (f_imm),
    .cls     (f_cls)
  );

  // State and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: ir is a plain register, not a memory, so it is reset to keep datapath_in defined after reset.
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; always_comb logic uses blocking.
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; instr is captured only on the edge leaving WAIT.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (f_cls)
          CLS_MOVI:          state_d = S_WRITE_IMM;
          CLS_ALU3, CLS_CMP: state_d = S_GET_A;
          CLS_MOVR, CLS_MVN: state_d = S_GET_B;
          default:           state_d = S_WAIT;
        endcase
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = (f_cls == CLS_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  // Moore output decode from state and the latched instruction only.
  always_comb begin
    w        = 1'b0;
    illegal  = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    shift    = SHIFT_NONE;
    ALUop    = ALU_ADD;
    case (state_q)
      S_WAIT:   w = 1'b1;
      S_DECODE: illegal = (f_cls == CLS_ILLEGAL);
      S_GET_A: begin
        readnum = f_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = f_rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = f_sh;
        ALUop = (f_cls == CLS_MOVR) ? ALU_ADD : f_op;
        asel  = (f_cls == CLS_MOVR);
        loadc = (f_cls != CLS_CMP);
        loads = (f_cls == CLS_CMP);
      end
      S_WRITE_REG: begin
        // shift/ALUop stay at their EXEC values; loadc is low so C is not disturbed.
        shift    = f_sh;
        ALUop    = (f_cls == CLS_MOVR) ? ALU_ADD : f_op;
        vsel     = 1'b0;
        write    = 1'b1;
        writenum = f_rd;
      end
      S_WRITE_IMM: begin
        vsel     = 1'b1;
        write    = 1'b1;
        writenum = f_rn;
      end
      default: w = 1'b0;
    endcase
  end

  assign bsel        = 1'b0;
  assign datapath_in = f_imm;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed, table-driven bench for datapath_controller.
module tb_datapath_controller;

  typedef struct packed {
    logic        w;
    logic        illegal;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] dpin;
  } outs_t;

  typedef struct {
    logic        s;
    logic [15:0] instr;
    outs_t       exp;
  } vec_t;

  logic        clk, rst_n, s;
  logic [15:0] instr;
  logic        w, illegal, write, vsel, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, alu_op;
  logic [15:0] datapath_in;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];

  datapath_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s),
    .instr       (instr),
    .w           (w),
    .illegal     (illegal),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .vsel        (vsel),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .bsel        (bsel),
    .shift       (shift),
    .ALUop       (alu_op),
    .datapath_in (datapath_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mk(logic w_e, logic ill, logic [2:0] rdn, logic [2:0] wrn,
                               logic wr, logic vs, logic la, logic lb, logic lc, logic ls,
                               logic as, logic [1:0] sh, logic [1:0] alu, logic [15:0] dp);
    outs_t o;
    o = '{w: w_e, illegal: ill, readnum: rdn, writenum: wrn, write: wr, vsel: vs,
          loada: la, loadb: lb, loadc: lc, loads: ls, asel: as, bsel: 1'b0,
          shift: sh, aluop: alu, dpin: dp};
    return o;
  endfunction

  function automatic outs_t idle(logic [15:0] dp);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dp);
  endfunction

  function automatic outs_t dec(logic [15:0] dp);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dp);
  endfunction

  function automatic outs_t cur();
    outs_t o;
    o = '{w: w, illegal: illegal, readnum: readnum, writenum: writenum, write: write,
          vsel: vsel, loada: loada, loadb: loadb, loadc: loadc, loads: loads, asel: asel,
          bsel: bsel, shift: shift, aluop: alu_op, dpin: datapath_in};
    return o;
  endfunction

  task automatic add(input logic sv, input logic [15:0] iv, input outs_t e);
    vec_t v;
    v.s = sv; v.instr = iv; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // mk(w, ill, readnum, writenum, write, vsel, la, lb, lc, ls, asel, shift, aluop, dpin)
    add(0, 16'h1234, idle(16'h0000));                                   // s low: stay
    // MOV R0,#-5
    add(1, 16'hD0FB, dec(16'hFFFB));
    add(0, 16'h0000, mk(0,0,0,0,1,1,0,0,0,0,0,0,0,16'hFFFB));           // WRITE_IMM
    add(0, 16'h0000, idle(16'hFFFB));
    // ADD R2,R1,R0,LSL#1 ; s and instr toggled mid-flight must be ignored
    add(1, 16'hA148, dec(16'h0048));
    add(1, 16'hFFFF, mk(0,0,1,0,0,0,1,0,0,0,0,0,0,16'h0048));           // GET_A
    add(0, 16'h0000, mk(0,0,0,0,0,0,0,1,0,0,0,0,0,16'h0048));           // GET_B
    add(0, 16'h0000, mk(0,0,0,0,0,0,0,0,1,0,0,1,0,16'h0048));           // EXEC
    add(0, 16'h0000, mk(0,0,0,2,1,0,0,0,0,0,0,1,0,16'h0048));           // WRITE_REG
    add(1, 16'h0000, idle(16'h0048));
    // CMP R1,R0
    add(1, 16'hA900, dec(16'h0000));
    add(0, 16'h0000, mk(0,0,1,0,0,0,1,0,0,0,0,0,0,16'h0000));
    add(0, 16'h0000, mk(0,0,0,0,0,0,0,1,0,0,0,0,0,16'h0000));
    add(0, 16'h0000, mk(0,0,0,0,0,0,0,0,0,1,0,0,1,16'h0000));           // loads, no loadc
    add(0, 16'h0000, idle(16'h0000));
    // MOV R3,R0
    add(1, 16'hC060, dec(16'h0060));
    add(0, 16'h0000, mk(0,0,0,0,0,0,0,1,0,0,0,0,0,16'h0060));           // GET_B directly
    add(0, 16'h0000, mk(0,0,0,0,0,0,0,0,1,0,1,0,0,16'h0060));           // asel=1
    add(0, 16'h0000, mk(0,0,0,3,1,0,0,0,0,0,0,0,0,16'h0060));
    add(0, 16'h0000, idle(16'h0060));
    // MVN R4,R3
    add(1, 16'hB883, dec(16'hFF83));
    add(0, 16'h0000, mk(0,0,3,0,0,0,0,1,0,0,0,0,0,16'hFF83));
    add(0, 16'h0000, mk(0,0,0,0,0,0,0,0,1,0,0,0,3,16'hFF83));
    add(0, 16'h0000, mk(0,0,0,4,1,0,0,0,0,0,0,0,3,16'hFF83));
    add(0, 16'h0000, idle(16'hFF83));
    // AND R5,R6,R7,ASR
    add(1, 16'hB6BF, dec(16'hFFBF));
    add(0, 16'h0000, mk(0,0,6,0,0,0,1,0,0,0,0,0,0,16'hFFBF));
    add(0, 16'h0000, mk(0,0,7,0,0,0,0,1,0,0,0,0,0,16'hFFBF));
    add(0, 16'h0000, mk(0,0,0,0,0,0,0,0,1,0,0,3,2,16'hFFBF));
    add(0, 16'h0000, mk(0,0,0,5,1,0,0,0,0,0,0,3,2,16'hFFBF));
    add(0, 16'h0000, idle(16'hFFBF));
    // Illegal opcode 111, then back-to-back with s held high
    add(1, 16'hE000, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,16'h0000));
    add(1, 16'hD27F, idle(16'h0000));                                   // s in DECODE ignored
    add(1, 16'hD27F, dec(16'h007F));                                    // MOV R2,#127
    add(1, 16'hD27F, mk(0,0,0,2,1,1,0,0,0,0,0,0,0,16'h007F));
    add(1, 16'hC800, idle(16'h007F));
    add(1, 16'hC800, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,16'h0000));           // 110/01 illegal
    add(0, 16'h0000, idle(16'h0000));

    rst_n = 1'b0;
    s     = 1'b0;
    instr = 16'h0000;
    #12;
    check("reset_state", cur(), idle(16'h0000));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      s     = vecs[i].s;
      instr = vecs[i].instr;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_%h", i, vecs[i].instr), cur(), vecs[i].exp);
    end

    // Reset asserted while ADD sits in GET_B.
    s = 1'b1; instr = 16'hA148;
    @(posedge clk); @(negedge clk);
    s = 1'b0; instr = 16'h0000;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("mid_add_get_b", cur(), mk(0,0,0,0,0,0,0,1,0,0,0,0,0,16'h0048));
    #2 rst_n = 1'b0;
    #1 check("async_reset_abort", cur(), idle(16'h0000));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("post_reset_idle%0d", i), cur(), idle(16'h0000));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
